// File: rtl/adc_sched_pkg.sv
// Shared types and constants for the ADC sample scheduler.
package adc_sched_pkg;

  localparam int DATA_W   = 8;
  localparam int CHAN_W   = 1;
  localparam int NUM_CHAN = 2;
  localparam int AVG_LOG2 = 2;

  typedef logic [2:0] state_t;

  localparam state_t HOLDOFF     = 3'd0;
  localparam state_t PRIME_START = 3'd1;
  localparam state_t IDLE        = 3'd2;
  localparam state_t START       = 3'd3;
  localparam state_t WAIT        = 3'd4;
  localparam state_t STORE       = 3'd5;

  // Counters only ever hold values up to (CYC - 1), so clog2 of the largest CYC is enough.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/adc_sched_avg.sv
// Per-channel 4-sample accumulator; only instantiated when ADC_SCHED_AVG_EN is defined.
module adc_sched_avg
  import adc_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [CHAN_W-1:0] in_chan,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  localparam int SUM_W = DATA_W + AVG_LOG2;
  localparam logic [AVG_LOG2-1:0] CNT_ONE = AVG_LOG2'(1);

  logic [NUM_CHAN-1:0][SUM_W-1:0] sum_next;
  logic [NUM_CHAN-1:0]            last;

  genvar gi;
  for (gi = 0; gi < NUM_CHAN; gi++) begin : g_acc
    logic [SUM_W-1:0]    sum_reg;
    logic [AVG_LOG2-1:0] cnt_reg;

    assign sum_next[gi] = sum_reg + SUM_W'(in_data);
    assign last[gi]     = &cnt_reg;

    always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
        sum_reg <= '0;
        cnt_reg <= '0;
      end else if (in_valid && (in_chan == CHAN_W'(gi))) begin
        if (last[gi]) begin
          sum_reg <= '0;
          cnt_reg <= '0;
        end else begin
          sum_reg <= sum_next[gi];
          cnt_reg <= cnt_reg + CNT_ONE;
        end
      end
    end
  end

  // The final sample is folded in combinationally so the mean leaves with the 4th result.
  assign out_valid = in_valid && last[in_chan];
  assign out_data  = sum_next[in_chan][SUM_W-1:AVG_LOG2];

endmodule

// File: rtl/adc_sample_scheduler.sv
// Conversion scheduler for an 8-bit dual-channel serial ADC: hold-off, periodic starts, pipelined channel attribution.
// Define ADC_SCHED_AVG_EN to publish the mean of every 4 results per channel instead of each result.
module adc_sample_scheduler
  import adc_sched_pkg::*;
#(
  parameter int         HOLDOFF_CYC = 4800,
  parameter int         PERIOD_CYC  = 480,
  parameter int         TIMEOUT_CYC = 256,
  parameter logic [1:0] CHAN_MASK   = 2'b11
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       adc_start,
  output logic       adc_chan,
  input  logic       adc_done,
  input  logic [7:0] adc_data,
  output logic [7:0] ch0_data,
  output logic [7:0] ch1_data,
  output logic       sample_valid,
  output logic       sample_chan,
  output logic       timeout_err,
  output logic       overrun
);

  localparam int CNT_W = cnt_width(HOLDOFF_CYC, PERIOD_CYC, TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_CYC - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(PERIOD_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  // Next enabled channel in ascending order, wrapping; a single-bit mask always returns itself.
  function automatic logic [CHAN_W-1:0] next_chan(input logic [CHAN_W-1:0] cur);
    logic [CHAN_W-1:0] cand;
    next_chan = cur;
    for (int i = NUM_CHAN; i >= 1; i--) begin
      cand = CHAN_W'((int'(cur) + i) % NUM_CHAN);
      if (CHAN_MASK[cand]) next_chan = cand;
    end
  endfunction

  localparam logic [CHAN_W-1:0] FIRST_CHAN = next_chan(CHAN_W'(NUM_CHAN - 1));

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  holdoff_cnt_reg, holdoff_cnt_next;
  logic [CNT_W-1:0]  period_cnt_reg, period_cnt_next;
  logic [CNT_W-1:0]  timeout_cnt_reg, timeout_cnt_next;
  logic [CHAN_W-1:0] chan_reg, chan_next;
  logic [CHAN_W-1:0] prev_chan_reg, prev_chan_next;
  logic              prime_reg, prime_next;
  logic              sample_valid_reg, sample_chan_reg;
  logic              timeout_err_reg, overrun_reg;

  logic              tick, holdoff_exit, timeout_hit, accept_store;
  logic              store_fire;
  logic [DATA_W-1:0] store_data;
  logic [NUM_CHAN-1:0][DATA_W-1:0] ch_q;

  assign tick         = (state_reg != HOLDOFF) && (period_cnt_reg == PERIOD_LAST);
  assign timeout_hit  = en && (state_reg == WAIT) && !adc_done && (timeout_cnt_reg == TIMEOUT_LAST);
  assign accept_store = en && (state_reg == WAIT) && adc_done && !prime_reg;
  assign holdoff_exit = (state_reg == HOLDOFF) && (state_next == PRIME_START);

  always_comb begin
    state_next = state_reg;
    if (!en) begin
      state_next = HOLDOFF;
    end else begin
      case (state_reg)
        HOLDOFF:            if (holdoff_cnt_reg == HOLDOFF_LAST) state_next = PRIME_START;
        PRIME_START, START: state_next = WAIT;
        WAIT: begin
          // A done pulse in the expiry cycle still counts as a good conversion.
          if (adc_done)                             state_next = prime_reg ? IDLE : STORE;
          else if (timeout_cnt_reg == TIMEOUT_LAST) state_next = HOLDOFF;
        end
        STORE:              state_next = IDLE;
        IDLE:               if (tick) state_next = START;
        default:            state_next = HOLDOFF;
      endcase
    end
  end

  always_comb begin
    holdoff_cnt_next = ((state_reg == HOLDOFF) && en && !holdoff_exit) ? holdoff_cnt_reg + CNT_ONE : '0;
    period_cnt_next  = ((state_reg == HOLDOFF) || (state_next == HOLDOFF) || tick) ? '0
                                                                                  : period_cnt_reg + CNT_ONE;
    timeout_cnt_next = (state_reg == WAIT) ? timeout_cnt_reg + CNT_ONE : '0;

    chan_next      = chan_reg;
    prev_chan_next = prev_chan_reg;
    prime_next     = prime_reg;
    if (holdoff_exit) begin
      chan_next  = FIRST_CHAN;
      prime_next = 1'b1;
    end else if (state_next == START) begin
      // The ADC returns the previous address's result while this one is shifted out.
      prev_chan_next = chan_reg;
      chan_next      = next_chan(chan_reg);
      prime_next     = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_reg        <= HOLDOFF;
      holdoff_cnt_reg  <= '0;
      period_cnt_reg   <= '0;
      timeout_cnt_reg  <= '0;
      chan_reg         <= '0;
      prev_chan_reg    <= '0;
      prime_reg        <= 1'b0;
      sample_valid_reg <= 1'b0;
      sample_chan_reg  <= 1'b0;
      timeout_err_reg  <= 1'b0;
      overrun_reg      <= 1'b0;
    end else begin
      state_reg        <= state_next;
      holdoff_cnt_reg  <= holdoff_cnt_next;
      period_cnt_reg   <= period_cnt_next;
      timeout_cnt_reg  <= timeout_cnt_next;
      chan_reg         <= chan_next;
      prev_chan_reg    <= prev_chan_next;
      prime_reg        <= prime_next;
      sample_valid_reg <= store_fire;
      if (store_fire) sample_chan_reg <= prev_chan_reg;
      timeout_err_reg  <= en && (timeout_err_reg || timeout_hit);
      overrun_reg      <= en && (overrun_reg || (tick && (state_reg != IDLE)));
    end
  end

`ifdef ADC_SCHED_AVG_EN
  logic avg_clr;
  assign avg_clr = !en || timeout_hit;

  adc_sched_avg u_avg (
    .clk      (sys_clk),
    .rst_n    (rst_n),
    .clr      (avg_clr),
    .in_valid (accept_store),
    .in_chan  (prev_chan_reg),
    .in_data  (adc_data),
    .out_valid(store_fire),
    .out_data (store_data)
  );
`else
  assign store_fire = accept_store;
  assign store_data = adc_data;
`endif

  genvar gi;
  for (gi = 0; gi < NUM_CHAN; gi++) begin : g_ch
    logic [DATA_W-1:0] data_reg;
    always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
        data_reg <= '0;
      end else if (store_fire && (prev_chan_reg == CHAN_W'(gi))) begin
        data_reg <= store_data;
      end
    end
    assign ch_q[gi] = data_reg;
  end

  assign adc_start    = (state_reg == PRIME_START) || (state_reg == START);
  assign adc_chan     = chan_reg;
  assign ch0_data     = ch_q[0];
  assign ch1_data     = ch_q[1];
  assign sample_valid = sample_valid_reg;
  assign sample_chan  = sample_chan_reg;
  assign timeout_err  = timeout_err_reg;
  assign overrun      = overrun_reg;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Directed bench: main scheduler, a long-timeout copy for overrun, and a single-channel copy for averaging.
module tb_adc_sample_scheduler;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic rst_n, en, en_o, en_a;
  logic [2:0] starts, dones, chans, valids, schans, terrs, ovrs;
  logic [2:0][7:0] c0, c1;

  int         mdly [3] = '{6, 45, 6};
  logic [7:0] mdat [3] = '{8'h00, 8'h00, 8'h00};
  logic [2:0] msil     = 3'b000;
  int         mcnt [3] = '{0, 0, 0};
  int         sv_cnt [3] = '{0, 0, 0};
  logic [7:0] avg_vals [4] = '{8'h10, 8'h20, 8'h30, 8'h41};

  int vectors = 0;
  int miscompares = 0;

  adc_sample_scheduler #(.HOLDOFF_CYC(16), .PERIOD_CYC(40), .TIMEOUT_CYC(20), .CHAN_MASK(2'b11)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .en(en),
    .adc_start(starts[0]), .adc_chan(chans[0]), .adc_done(dones[0]), .adc_data(mdat[0]),
    .ch0_data(c0[0]), .ch1_data(c1[0]), .sample_valid(valids[0]), .sample_chan(schans[0]),
    .timeout_err(terrs[0]), .overrun(ovrs[0])
  );

  adc_sample_scheduler #(.HOLDOFF_CYC(16), .PERIOD_CYC(40), .TIMEOUT_CYC(60), .CHAN_MASK(2'b11)) dut_ovr (
    .sys_clk(sys_clk), .rst_n(rst_n), .en(en_o),
    .adc_start(starts[1]), .adc_chan(chans[1]), .adc_done(dones[1]), .adc_data(mdat[1]),
    .ch0_data(c0[1]), .ch1_data(c1[1]), .sample_valid(valids[1]), .sample_chan(schans[1]),
    .timeout_err(terrs[1]), .overrun(ovrs[1])
  );

  adc_sample_scheduler #(.HOLDOFF_CYC(16), .PERIOD_CYC(40), .TIMEOUT_CYC(20), .CHAN_MASK(2'b01)) dut_avg (
    .sys_clk(sys_clk), .rst_n(rst_n), .en(en_a),
    .adc_start(starts[2]), .adc_chan(chans[2]), .adc_done(dones[2]), .adc_data(mdat[2]),
    .ch0_data(c0[2]), .ch1_data(c1[2]), .sample_valid(valids[2]), .sample_chan(schans[2]),
    .timeout_err(terrs[2]), .overrun(ovrs[2])
  );

  // ADC models: done pulses mdly cycles after the start cycle unless silenced.
  always @(posedge sys_clk) begin
    for (int i = 0; i < 3; i++) begin
      if (starts[i]) mcnt[i] <= mdly[i];
      else if (mcnt[i] > 0) mcnt[i] <= mcnt[i] - 1;
      if (valids[i]) sv_cnt[i] <= sv_cnt[i] + 1;
    end
  end

  assign dones[0] = (mcnt[0] == 1) && !msil[0];
  assign dones[1] = (mcnt[1] == 1) && !msil[1];
  assign dones[2] = (mcnt[2] == 1) && !msil[2];

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) $display("vec %0d %s: observed %0h", vectors, tag, obs);
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input int sel, input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!starts[sel] && n < limit);
    if (!starts[sel]) n = -1;
  endtask

  task automatic wait_done(input int sel, input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!dones[sel] && n < limit);
    if (!dones[sel]) n = -1;
  endtask

  initial begin
    int n;
    int base;
    rst_n = 1'b0; en = 1'b0; en_o = 1'b0; en_a = 1'b0;
    repeat (3) step();
    check("rst_adc_start",    32'(starts[0]), 32'd0);
    check("rst_adc_chan",     32'(chans[0]),  32'd0);
    check("rst_ch0_data",     32'(c0[0]),     32'd0);
    check("rst_ch1_data",     32'(c1[0]),     32'd0);
    check("rst_sample_valid", 32'(valids[0]), 32'd0);
    check("rst_sample_chan",  32'(schans[0]), 32'd0);
    check("rst_timeout_err",  32'(terrs[0]),  32'd0);
    check("rst_overrun",      32'(ovrs[0]),   32'd0);

    // Hold-off, prime and attribution
    rst_n = 1'b1; en = 1'b1;
    wait_start(0, 100, n);
    check("holdoff_len", n, 32'd16);
    check("prime_chan", 32'(chans[0]), 32'd0);
    mdat[0] = 8'h11;
    base = sv_cnt[0];
    wait_start(0, 100, n);
    check("period_prime_to_start", n, 32'd40);
    check("prime_dropped", sv_cnt[0] - base, 32'd0);
    check("start2_chan", 32'(chans[0]), 32'd1);
    mdat[0] = 8'hA0;
    wait_done(0, 100, n);
    check("done_delay", n, 32'd6);
    step();
    check("a0_valid", 32'(valids[0]), 32'd1);
    check("a0_chan",  32'(schans[0]), 32'd0);
    check("a0_ch0",   32'(c0[0]),     32'h0A0);
    step();
    check("valid_one_cycle", 32'(valids[0]), 32'd0);
    wait_start(0, 100, n);
    check("start3_wait", n, 32'd32);
    check("start3_chan", 32'(chans[0]), 32'd0);
    mdat[0] = 8'h5B;
    wait_done(0, 100, n);
    step();
    check("5b_valid", 32'(valids[0]), 32'd1);
    check("5b_chan",  32'(schans[0]), 32'd1);
    check("5b_ch1",   32'(c1[0]),     32'h05B);
    check("5b_ch0_kept", 32'(c0[0]),  32'h0A0);

    // Timeout
    msil[0] = 1'b1;
    wait_start(0, 100, n);
    check("start4_wait", n, 32'd33);
    base = sv_cnt[0];
    n = 0;
    do begin
      step();
      n++;
    end while (!terrs[0] && n < 100);
    check("timeout_latency", n, 32'd21);
    check("timeout_no_valid", sv_cnt[0] - base, 32'd0);
    msil[0] = 1'b0;
    wait_start(0, 100, n);
    check("reprime_holdoff", n, 32'd16);
    check("reprime_chan", 32'(chans[0]), 32'd0);
    mdat[0] = 8'h33;
    wait_start(0, 100, n);
    check("reprime_period", n, 32'd40);
    check("timeout_sticky", 32'(terrs[0]), 32'd1);

    // en drop while waiting
    mdat[0] = 8'hEE;
    base = sv_cnt[0];
    step();
    step();
    en = 1'b0;
    repeat (10) step();
    check("endrop_no_valid", sv_cnt[0] - base, 32'd0);
    check("endrop_terr_clr", 32'(terrs[0]), 32'd0);
    check("endrop_ovr",      32'(ovrs[0]),  32'd0);
    check("endrop_ch0",      32'(c0[0]),    32'h0A0);
    check("endrop_ch1",      32'(c1[0]),    32'h05B);
    check("endrop_no_start", 32'(starts[0]), 32'd0);
    en = 1'b1;
    wait_start(0, 100, n);
    check("reenable_holdoff", n, 32'd16);

    // Overrun on the long-timeout instance
    en_o = 1'b1;
    wait_start(1, 100, n);
    check("ovr_holdoff", n, 32'd16);
    repeat (39) step();
    check("ovr_before_tick", 32'(ovrs[1]), 32'd0);
    step();
    check("ovr_set", 32'(ovrs[1]), 32'd1);
    wait_start(1, 100, n);
    check("ovr_no_late_start", n, 32'd40);
    check("ovr_no_timeout", 32'(terrs[1]), 32'd0);

    // Single-channel mask and averaging
    en_a = 1'b1;
    wait_start(2, 100, n);
    check("avg_holdoff", n, 32'd16);
    mdat[2] = 8'h99;
    base = sv_cnt[2];
    for (int k = 0; k < 4; k++) begin
      wait_start(2, 100, n);
      check("avg_period", n, 32'd40);
      check("avg_chan", 32'(chans[2]), 32'd0);
      mdat[2] = avg_vals[k];
    end
    repeat (10) step();
`ifdef ADC_SCHED_AVG_EN
    check("avg_valid_count", sv_cnt[2] - base, 32'd1);
    check("avg_ch0", 32'(c0[2]), 32'h028);
`else
    check("avg_valid_count", sv_cnt[2] - base, 32'd4);
    check("avg_ch0", 32'(c0[2]), 32'h041);
`endif
    check("avg_ch1", 32'(c1[2]), 32'd0);
    check("avg_sample_chan", 32'(schans[2]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
